// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg                                                              |
// | Shared AES constants, key-length encoding, key-expander FSM states. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_WORD_W     = 32;
  localparam int AES_BLK_W      = 128;
  localparam int AES128_LAST_RK = 10;
  localparam int AES256_LAST_RK = 14;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  localparam logic KEY_LEN_128 = 1'b0;
  localparam logic KEY_LEN_256 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_FIN  = 2'd2
  } kx_state_t;

  // Multiply by x in GF(2^8); used to advance the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_sbox                                                             |
// | Combinational 8-bit AES forward S-box (table lookup).                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0x00 occupies the most significant byte.
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_idx;

  assign w_idx    = 11'd2047 - {in_byte, 3'b000};
  assign out_byte = c_sbox[w_idx -: 8];

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_key_expand                                                       |
// | AES-128/256 key schedule, one round key per cycle into key memory.   |
// | Optional abort input: define AES_KEY_EXPAND_ABORT_EN.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NK_MAX = 8,
  parameter int ADDR_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         key_len,
  input  logic [NK_MAX*AES_WORD_W-1:0] key_in,
`ifdef AES_KEY_EXPAND_ABORT_EN
  input  logic                         abort,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [AES_BLK_W-1:0]         mem_data
);

  localparam int c_key_w = NK_MAX * AES_WORD_W;

  kx_state_t             r_state;
  logic                  r_len;
  logic [AES_BLK_W-1:0]  r_prev;
  logic [AES_BLK_W-1:0]  r_prev2;
  logic [7:0]            r_rcon;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [AES_BLK_W-1:0]  r_data;

  logic                  w_abort;
  logic [ADDR_W-1:0]     w_k;
  logic [ADDR_W-1:0]     w_last_addr;
  logic                  w_rot;
  logic [AES_WORD_W-1:0] w_sub_in;
  logic [AES_WORD_W-1:0] w_sub_out;
  logic [AES_WORD_W-1:0] w_t;
  logic [AES_BLK_W-1:0]  w_base;
  logic [AES_WORD_W-1:0] w_w0, w_w1, w_w2, w_w3;
  logic [AES_BLK_W-1:0]  w_next;

`ifdef AES_KEY_EXPAND_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_k         = r_addr + ADDR_W'(1);
  assign w_last_addr = (r_len == KEY_LEN_256) ? ADDR_W'(AES256_LAST_RK) : ADDR_W'(AES128_LAST_RK);

  // AES-256 odd round keys take SubWord without rotation or round constant.
  assign w_rot    = (r_len == KEY_LEN_128) || !w_k[0];
  assign w_sub_in = w_rot ? {r_prev[23:0], r_prev[31:24]} : r_prev[31:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (w_sub_in[8*gi +: 8]),
        .out_byte (w_sub_out[8*gi +: 8])
      );
    end
  endgenerate

  assign w_t    = w_sub_out ^ (w_rot ? {r_rcon, 24'h0} : 32'h0);
  assign w_base = (r_len == KEY_LEN_256) ? r_prev2 : r_prev;
  assign w_w0   = w_base[127:96] ^ w_t;
  assign w_w1   = w_base[95:64]  ^ w_w0;
  assign w_w2   = w_base[63:32]  ^ w_w1;
  assign w_w3   = w_base[31:0]   ^ w_w2;
  assign w_next = {w_w0, w_w1, w_w2, w_w3};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_len   <= KEY_LEN_128;
      r_prev  <= '0;
      r_prev2 <= '0;
      r_rcon  <= RCON_INIT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_len   <= key_len;
            r_prev  <= key_in[c_key_w-1 -: AES_BLK_W];
            r_prev2 <= key_in[c_key_w-AES_BLK_W-1 -: AES_BLK_W];
            r_rcon  <= RCON_INIT;
            r_we    <= 1'b1;
            r_addr  <= '0;
            r_data  <= key_in[c_key_w-1 -: AES_BLK_W];
            r_busy  <= 1'b1;
            r_state <= ST_GEN;
          end
        end
        ST_GEN: begin
          if (w_abort) begin
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_prev  <= '0;
            r_prev2 <= '0;
            r_state <= ST_IDLE;
          end else if (r_addr == w_last_addr) begin
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_we   <= 1'b1;
            r_addr <= w_k;
            if ((r_len == KEY_LEN_256) && (r_addr == '0)) begin
              // Second half of the 256-bit key is round key 1; swap history.
              r_data  <= r_prev2;
              r_prev  <= r_prev2;
              r_prev2 <= r_prev;
            end else begin
              r_data  <= w_next;
              r_prev  <= w_next;
              r_prev2 <= r_prev;
              if (w_rot) begin
                r_rcon <= xtime(r_rcon);
              end
            end
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_we   = r_we;
  assign mem_addr = r_addr;
  assign mem_data = r_data;

endmodule
`default_nettype wire
